// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: default Q format, signed range limits and reduction.
package fxp_pkg;

   // Wide working type; covers a full 2*bits product for bits up to 32.
   localparam int unsigned FXP_CALC_W    = 64;
   localparam int unsigned FXP_BITS      = 16;
   localparam int unsigned FXP_FRAC_BITS = 8;

   typedef logic signed [FXP_CALC_W-1:0] fxp_calc_t;

   // Largest signed value representable in w bits.
   function automatic fxp_calc_t fxp_smax(input int unsigned w);
      return (fxp_calc_t'(1) <<< (w - 1)) - fxp_calc_t'(1);
   endfunction

   // Smallest signed value representable in w bits.
   function automatic fxp_calc_t fxp_smin(input int unsigned w);
      return -(fxp_calc_t'(1) <<< (w - 1));
   endfunction

   // True when v does not fit a signed w-bit word.
   function automatic logic fxp_overflow(input fxp_calc_t v, input int unsigned w);
      return (v > fxp_smax(w)) || (v < fxp_smin(w));
   endfunction

   // Clamp to the w-bit signed range when sat is set; otherwise pass v through so
   // the caller's truncation to w bits yields the wrapped result.
   function automatic fxp_calc_t fxp_reduce(input fxp_calc_t v, input int unsigned w,
                                            input logic sat);
      fxp_calc_t r;
      r = v;
      if (sat && (v > fxp_smax(w))) r = fxp_smax(w);
      if (sat && (v < fxp_smin(w))) r = fxp_smin(w);
      return r;
   endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational Q-format multiply: full product, floor shift, reduce to bits.
module fxp_mul
   import fxp_pkg::*;
#(
   parameter int unsigned bits            = FXP_BITS,
   parameter int unsigned fractional_bits = FXP_FRAC_BITS,
   parameter int unsigned SATURATE        = 0
) (
   input  logic signed [bits-1:0] a_i,
   input  logic signed [bits-1:0] b_i,
   output logic signed [bits-1:0] product_o_c,
   output logic                   ovf_o_c
);

   logic signed [2*bits-1:0] full;
   logic signed [2*bits-1:0] shifted;

   // Arithmetic shift truncates toward minus infinity.
   always_comb begin
      full        = (2*bits)'(a_i) * (2*bits)'(b_i);
      shifted     = full >>> fractional_bits;
      ovf_o_c     = fxp_overflow(fxp_calc_t'(shifted), bits);
      product_o_c = bits'(fxp_reduce(fxp_calc_t'(shifted), bits, SATURATE != 0));
   end

endmodule

// File: rtl/fxp_mul_add.sv
// Registered fixed-point unit producing A+B, scaled A*B and C+product each accepted cycle.
module fxp_mul_add
   import fxp_pkg::*;
#(
   parameter int unsigned bits            = FXP_BITS,
   parameter int unsigned fractional_bits = FXP_FRAC_BITS,
   parameter int unsigned SATURATE        = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic signed [bits-1:0] A,
   input  logic signed [bits-1:0] B,
   input  logic signed [bits-1:0] C,
   output logic                   out_valid,
   output logic        [bits-1:0] Sum,
   output logic        [bits-1:0] Product,
   output logic        [bits-1:0] Mac,
   output logic                   overflow
);

   logic signed [bits-1:0] prod_c;
   logic                   prod_ovf_c;
   logic signed [bits:0]   sum_x;
   logic signed [bits:0]   mac_x;
   logic                   sum_ovf;
   logic                   mac_ovf;

   logic [bits-1:0] sum_d, sum_q;
   logic [bits-1:0] prod_d, prod_q;
   logic [bits-1:0] mac_d, mac_q;
   logic            ovf_d, ovf_q;
   logic            valid_d, valid_q;

   fxp_mul #(
      .bits            (bits),
      .fractional_bits (fractional_bits),
      .SATURATE        (SATURATE)
   ) u_mul (
      .a_i         (A),
      .b_i         (B),
      .product_o_c (prod_c),
      .ovf_o_c     (prod_ovf_c)
   );

   // Exact (bits+1)-bit adds, reduce, and load the result registers on a valid cycle.
   always_comb begin
      sum_d   = sum_q;
      prod_d  = prod_q;
      mac_d   = mac_q;
      ovf_d   = ovf_q;
      valid_d = in_valid;

      sum_x   = (bits+1)'(A) + (bits+1)'(B);
      mac_x   = (bits+1)'(C) + (bits+1)'(prod_c);
      sum_ovf = fxp_overflow(fxp_calc_t'(sum_x), bits);
      mac_ovf = fxp_overflow(fxp_calc_t'(mac_x), bits);

      if (in_valid) begin
         sum_d  = bits'(fxp_reduce(fxp_calc_t'(sum_x), bits, SATURATE != 0));
         prod_d = prod_c;
         mac_d  = bits'(fxp_reduce(fxp_calc_t'(mac_x), bits, SATURATE != 0));
         ovf_d  = sum_ovf | prod_ovf_c | mac_ovf;
      end
   end

   // Output register stage; reset wins over a simultaneous operand set.
   always_ff @(posedge clock) begin
      if (reset) begin
         sum_q   <= '0;
         prod_q  <= '0;
         mac_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         prod_q  <= prod_d;
         mac_q   <= mac_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign Sum       = sum_q;
   assign Product   = prod_q;
   assign Mac       = mac_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_fxp_mul_add.sv
// Bench for fxp_mul_add: wrap and saturate instances against an integer reference model.
module tb_fxp_mul_add;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [15:0] A, B, C;

   logic        valid_w, ovf_w, valid_s, ovf_s;
   logic [15:0] sum_w, prod_w, mac_w, sum_s, prod_s, mac_s;

   // Expected register contents: {Sum, Product, Mac, overflow}
   logic [48:0] exp_w, exp_s;
   logic        exp_v;

   int n_checks = 0;
   int n_fail   = 0;

   fxp_mul_add #(.bits(16), .fractional_bits(8), .SATURATE(0)) dut_wrap (
      .clock(clock), .reset(reset), .in_valid(in_valid), .A(A), .B(B), .C(C),
      .out_valid(valid_w), .Sum(sum_w), .Product(prod_w), .Mac(mac_w), .overflow(ovf_w)
   );

   fxp_mul_add #(.bits(16), .fractional_bits(8), .SATURATE(1)) dut_sat (
      .clock(clock), .reset(reset), .in_valid(in_valid), .A(A), .B(B), .C(C),
      .out_valid(valid_s), .Sum(sum_s), .Product(prod_s), .Mac(mac_s), .overflow(ovf_s)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Fit an exact integer into 16 bits: wrap or clamp, flag if out of range.
   function automatic logic [15:0] red(input longint v, input bit sat, inout bit ov);
      longint hi = 32767;
      longint lo = -32768;
      if (v > hi || v < lo) ov = 1'b1;
      if (sat && v > hi) return 16'h7FFF;
      if (sat && v < lo) return 16'h8000;
      return v[15:0];
   endfunction

   // Reference results using plain integer arithmetic on Q8.8 values.
   function automatic logic [48:0] model(input logic [15:0] a, b, c, input bit sat);
      longint    sa, sb, sc, p;
      logic [15:0] s_r, p_r, m_r;
      bit        ov;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      sc  = longint'($signed(c));
      ov  = 1'b0;
      s_r = red(sa + sb, sat, ov);
      p   = (sa * sb) >>> 8;
      p_r = red(p, sat, ov);
      m_r = red(sc + longint'($signed(p_r)), sat, ov);
      return {s_r, p_r, m_r, ov};
   endfunction

   // Drive one cycle, advance past the edge, and update the expected state.
   task automatic cycle(input logic rst, input logic v, input logic [15:0] a, b, c);
      reset    = rst;
      in_valid = v;
      A = a; B = b; C = c;
      @(posedge clock);
      #1;
      if (rst) begin
         exp_w = '0;
         exp_s = '0;
      end else if (v) begin
         exp_w = model(a, b, c, 1'b0);
         exp_s = model(a, b, c, 1'b1);
      end
      exp_v = v && !rst;
   endtask

   task automatic test_reset;
      cycle(1'b1, 1'b0, 16'h1234, 16'h5678, 16'h9ABC);
      cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
      n_checks++;
      if ({valid_w, sum_w, prod_w, mac_w, ovf_w} !== 50'h0) begin
         n_fail++;
         $display("FAIL reset_wrap: got %h want 0", {valid_w, sum_w, prod_w, mac_w, ovf_w});
      end
      n_checks++;
      if ({valid_s, sum_s, prod_s, mac_s, ovf_s} !== 50'h0) begin
         n_fail++;
         $display("FAIL reset_sat: got %h want 0", {valid_s, sum_s, prod_s, mac_s, ovf_s});
      end
   endtask

   task automatic test_directed;
      logic [15:0] ta[5] = '{16'h0180, 16'hFE80, 16'h0001, 16'hFFFF, 16'h7F00};
      logic [15:0] tb[5] = '{16'h0200, 16'h0200, 16'h0080, 16'h0080, 16'h0200};
      logic [15:0] tc[5] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      logic [48:0] kw[5] = '{{16'h0380, 16'h0300, 16'h0400, 1'b0},
                             {16'h0080, 16'hFD00, 16'hFD00, 1'b0},
                             {16'h0081, 16'h0000, 16'h0000, 1'b0},
                             {16'h007F, 16'hFFFF, 16'hFFFF, 1'b0},
                             {16'h8100, 16'hFE00, 16'hFE00, 1'b1}};
      logic [48:0] ks[5] = '{{16'h0380, 16'h0300, 16'h0400, 1'b0},
                             {16'h0080, 16'hFD00, 16'hFD00, 1'b0},
                             {16'h0081, 16'h0000, 16'h0000, 1'b0},
                             {16'h007F, 16'hFFFF, 16'hFFFF, 1'b0},
                             {16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1}};
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, ta[i], tb[i], tc[i]);
         n_checks++;
         if ({valid_w, sum_w, prod_w, mac_w, ovf_w} !== {1'b1, kw[i]}) begin
            n_fail++;
            $display("FAIL directed_wrap[%0d]: got %h want %h", i,
                     {valid_w, sum_w, prod_w, mac_w, ovf_w}, {1'b1, kw[i]});
         end
         n_checks++;
         if ({valid_s, sum_s, prod_s, mac_s, ovf_s} !== {1'b1, ks[i]}) begin
            n_fail++;
            $display("FAIL directed_sat[%0d]: got %h want %h", i,
                     {valid_s, sum_s, prod_s, mac_s, ovf_s}, {1'b1, ks[i]});
         end
         cycle(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 16'h0F0F);
         n_checks++;
         if ({valid_w, sum_w, prod_w, mac_w, ovf_w} !== {1'b0, kw[i]}) begin
            n_fail++;
            $display("FAIL directed_hold[%0d]: got %h want %h", i,
                     {valid_w, sum_w, prod_w, mac_w, ovf_w}, {1'b0, kw[i]});
         end
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom_range(0, 1023)), 16'($urandom));
         else       cycle(1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
         n_checks++;
         if ({valid_w, sum_w, prod_w, mac_w, ovf_w} !== {exp_v, exp_w} || valid_w !== (i < 4)) begin
            n_fail++;
            $display("FAIL b2b_wrap[%0d]: got %h want %h", i,
                     {valid_w, sum_w, prod_w, mac_w, ovf_w}, {exp_v, exp_w});
         end
         n_checks++;
         if ({valid_s, sum_s, prod_s, mac_s, ovf_s} !== {exp_v, exp_s}) begin
            n_fail++;
            $display("FAIL b2b_sat[%0d]: got %h want %h", i,
                     {valid_s, sum_s, prod_s, mac_s, ovf_s}, {exp_v, exp_s});
         end
      end
   endtask

   task automatic test_reset_priority;
      cycle(1'b0, 1'b1, 16'h0180, 16'h0200, 16'h0100);
      cycle(1'b1, 1'b1, 16'h7F00, 16'h0200, 16'h0100);
      n_checks++;
      if ({valid_w, sum_w, prod_w, mac_w, ovf_w} !== 50'h0 ||
          {valid_s, sum_s, prod_s, mac_s, ovf_s} !== 50'h0) begin
         n_fail++;
         $display("FAIL reset_priority: got %h / %h want 0",
                  {valid_w, sum_w, prod_w, mac_w, ovf_w}, {valid_s, sum_s, prod_s, mac_s, ovf_s});
      end
      cycle(1'b0, 1'b1, 16'hFE80, 16'h0200, 16'h0000);
      n_checks++;
      if ({valid_w, sum_w, prod_w, mac_w, ovf_w} !== {1'b1, 16'h0080, 16'hFD00, 16'hFD00, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_release_accept: got %h want %h",
                  {valid_w, sum_w, prod_w, mac_w, ovf_w}, {1'b1, 16'h0080, 16'hFD00, 16'hFD00, 1'b0});
      end
   endtask

   task automatic test_random;
      logic [15:0] a, b, c;
      logic        v, r;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            a = 16'($urandom);
            b = 16'($urandom);
         end else begin
            a = 16'(int'($urandom_range(0, 2047)) - 1024);
            b = 16'(int'($urandom_range(0, 2047)) - 1024);
         end
         c = 16'($urandom);
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 31) == 0);
         cycle(r, v, a, b, c);
         n_checks++;
         if ({valid_w, sum_w, prod_w, mac_w, ovf_w} !== {exp_v, exp_w}) begin
            n_fail++;
            $display("FAIL random_wrap[%0d]: A=%h B=%h C=%h got %h want %h", i, a, b, c,
                     {valid_w, sum_w, prod_w, mac_w, ovf_w}, {exp_v, exp_w});
         end
         n_checks++;
         if ({valid_s, sum_s, prod_s, mac_s, ovf_s} !== {exp_v, exp_s}) begin
            n_fail++;
            $display("FAIL random_sat[%0d]: A=%h B=%h C=%h got %h want %h", i, a, b, c,
                     {valid_s, sum_s, prod_s, mac_s, ovf_s}, {exp_v, exp_s});
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      A = '0; B = '0; C = '0;
      exp_w = '0;
      exp_s = '0;
      exp_v = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
